ram_rec_play_ctrl: RTL and testbench

- Record/playback sequencer that drives the single-port asynchronous-read RAM block: it generates that RAM's we, addr and din, and consumes its dout.
- In record mode it writes an incoming valid-qualified sample stream into RAM from address 0.
- In play mode it streams the recorded samples back out, in order, over a valid/ready handshake.
- Sits between a sample source (e.g. UART rx or ADC front end) and a downstream consumer.

---
 rtl/ram_rec_play_ctrl_pkg.sv | 8 +
 rtl/ram_rec_play_ctrl.sv | 93 +++++++++
 tb/tb_ram_rec_play_ctrl.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/ram_rec_play_ctrl_pkg.sv
// ram_rec_play_ctrl_pkg: shared state encoding for the record/playback sequencer
package ram_rec_play_ctrl_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REC  = 2'b01,
        PLAY = 2'b10
    } state_t;
endpackage

// File: rtl/ram_rec_play_ctrl.sv
// ram_rec_play_ctrl: records a valid-qualified sample stream into an async-read RAM and plays it back over valid/ready
// Ports: start_rec/stop_rec/start_play command pulses; in_valid/in_data/in_ready sample input;
// out_valid/out_data/out_ready playback output; ram_we/ram_addr/ram_din/ram_dout RAM side;
// count samples recorded, busy when not idle, done_tick one-cycle end-of-operation pulse.
module ram_rec_play_ctrl
    import ram_rec_play_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_rec,
    input  logic                  stop_rec,
    input  logic                  start_play,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  busy,
    output logic                  done_tick
);
    localparam logic [ADDR_WIDTH:0] CAP = {1'b1, {ADDR_WIDTH{1'b0}}};
    state_t state, state_d;
    logic [ADDR_WIDTH:0] rd_ptr, count_d, rd_ptr_d, count_inc, rd_ptr_inc;
    logic done_d;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            rd_ptr    <= '0;
            done_tick <= 1'b0;
        end else begin
            state     <= state_d;
            count     <= count_d;
            rd_ptr    <= rd_ptr_d;
            done_tick <= done_d;
        end
    end
    assign count_inc  = count + 1'b1;
    assign rd_ptr_inc = rd_ptr + 1'b1;
    always_comb begin
        state_d  = state;
        count_d  = count;
        rd_ptr_d = rd_ptr;
        done_d   = 1'b0;
        case (state)
            IDLE: begin
                if (start_rec) begin
                    state_d = REC;
                    count_d = '0;
                end else if (start_play && count != '0) begin
                    state_d  = PLAY;
                    rd_ptr_d = '0;
                end
            end
            REC: begin
                if (in_valid)
                    count_d = count_inc;
                // a sample arriving with stop_rec is still written; filling the RAM ends recording
                if (stop_rec || (in_valid && count_inc == CAP)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            PLAY: begin
                if (out_ready) begin
                    rd_ptr_d = rd_ptr_inc;
                    if (rd_ptr_inc == count) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
    assign busy      = state != IDLE;
    assign in_ready  = state == REC;
    assign out_valid = state == PLAY;
    assign ram_we    = in_ready & in_valid;
    assign ram_din   = in_ready ? in_data : '0;
    // async RAM read gives the current rd_ptr word with no added latency
    assign out_data  = out_valid ? ram_dout : '0;
    assign ram_addr  = in_ready ? count[ADDR_WIDTH-1:0] : out_valid ? rd_ptr[ADDR_WIDTH-1:0] : '0;
endmodule

// File: tb/tb_ram_rec_play_ctrl.sv
// tb_ram_rec_play_ctrl: directed vector table, reset-mid-play sequence and random stimulus against a queue model
module tb_ram_rec_play_ctrl;
    localparam int AW = 2;
    localparam int DW = 8;

    logic clk, reset;
    logic start_rec, stop_rec, start_play, in_valid, out_ready;
    logic [DW-1:0] in_data, out_data, ram_din, ram_dout;
    logic in_ready, out_valid, ram_we, busy, done_tick;
    logic [AW-1:0] ram_addr;
    logic [AW:0] count;

    ram_rec_play_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset), .start_rec(start_rec), .stop_rec(stop_rec),
        .start_play(start_play), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_dout(ram_dout), .count(count), .busy(busy),
        .done_tick(done_tick)
    );

    logic [DW-1:0] mem [2**AW];
    always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_din;
    assign ram_dout = mem[ram_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // model: 0 idle, 1 recording, 2 playing; q holds the recorded samples in order
    int mode = 0;
    int pidx = 0;
    bit mdone = 0;
    logic [DW-1:0] q[$];

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic drive(input logic sr, input logic stp, input logic sp, input logic iv,
                         input logic [DW-1:0] d, input logic ordy);
        start_rec = sr; stop_rec = stp; start_play = sp;
        in_valid = iv; in_data = d; out_ready = ordy;
        @(negedge clk);
        chk("busy", busy, mode != 0);
        chk("in_ready", in_ready, mode == 1);
        chk("out_valid", out_valid, mode == 2);
        chk("ram_we", ram_we, mode == 1 && iv);
        chk("count", count, q.size());
        chk("done_tick", done_tick, mdone);
        chk("ram_addr", ram_addr, mode == 1 ? q.size() : mode == 2 ? pidx : 0);
        if (mode == 1) chk("ram_din", ram_din, d);
        if (mode == 2) chk("out_data", out_data, q[pidx]);
    endtask

    task automatic tick();
        @(posedge clk);
        mdone = 0;
        if (mode == 0) begin
            if (start_rec) begin
                q.delete();
                mode = 1;
            end else if (start_play && q.size() > 0) begin
                mode = 2;
                pidx = 0;
            end
        end else if (mode == 1) begin
            if (in_valid) q.push_back(in_data);
            if (stop_rec || q.size() == 2**AW) begin
                mode = 0;
                mdone = 1;
            end
        end else if (out_ready) begin
            if (pidx == q.size() - 1) begin
                mode = 0;
                mdone = 1;
            end else pidx++;
        end
        #1;
    endtask

    typedef struct {
        logic sr, stp, sp, iv;
        logic [DW-1:0] d;
        logic ordy;
        logic busy, inr, ov;
        logic [DW-1:0] od;
        logic [AW:0] cnt;
        logic done;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic sr, input logic stp, input logic sp, input logic iv,
                               input logic [DW-1:0] d, input logic ordy, input logic b,
                               input logic inr, input logic ov, input logic [DW-1:0] od,
                               input logic [AW:0] cnt, input logic done);
        vec_t r;
        r.sr = sr; r.stp = stp; r.sp = sp; r.iv = iv; r.d = d; r.ordy = ordy;
        r.busy = b; r.inr = inr; r.ov = ov; r.od = od; r.cnt = cnt; r.done = done;
        return r;
    endfunction

    initial begin
        for (int i = 0; i < 2**AW; i++) mem[i] = '0;
        reset = 1'b1;
        start_rec = 0; stop_rec = 0; start_play = 0; in_valid = 0; in_data = 0; out_ready = 0;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_count", count, 0);
        chk("rst_done", done_tick, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_addr", ram_addr, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // record 11,22,33 with gaps, then play
        tbl.push_back(v(1,0,0,0,8'h00,0, 0,0,0,8'h00,0,0));
        tbl.push_back(v(0,0,0,1,8'h11,0, 1,1,0,8'h00,0,0));
        tbl.push_back(v(0,0,0,0,8'h00,0, 1,1,0,8'h00,1,0));
        tbl.push_back(v(0,0,0,1,8'h22,0, 1,1,0,8'h00,1,0));
        tbl.push_back(v(0,0,0,0,8'h00,0, 1,1,0,8'h00,2,0));
        tbl.push_back(v(0,0,0,1,8'h33,0, 1,1,0,8'h00,2,0));
        tbl.push_back(v(0,1,0,0,8'h00,0, 1,1,0,8'h00,3,0));
        tbl.push_back(v(0,0,0,0,8'h00,0, 0,0,0,8'h00,3,1));
        tbl.push_back(v(0,0,1,0,8'h00,1, 0,0,0,8'h00,3,0));
        tbl.push_back(v(0,0,0,0,8'h00,1, 1,0,1,8'h11,3,0));
        tbl.push_back(v(0,0,0,0,8'h00,1, 1,0,1,8'h22,3,0));
        tbl.push_back(v(0,0,0,0,8'h00,1, 1,0,1,8'h33,3,0));
        tbl.push_back(v(0,0,0,0,8'h00,0, 0,0,0,8'h00,3,1));
        // backpressure 1,0,0,1 with stray commands ignored during play
        tbl.push_back(v(0,0,1,0,8'h00,0, 0,0,0,8'h00,3,0));
        tbl.push_back(v(0,0,0,0,8'h00,1, 1,0,1,8'h11,3,0));
        tbl.push_back(v(1,1,0,1,8'h99,0, 1,0,1,8'h22,3,0));
        tbl.push_back(v(0,0,1,0,8'h00,0, 1,0,1,8'h22,3,0));
        tbl.push_back(v(0,0,0,0,8'h00,1, 1,0,1,8'h22,3,0));
        tbl.push_back(v(0,0,0,0,8'h00,1, 1,0,1,8'h33,3,0));
        tbl.push_back(v(0,0,0,0,8'h00,0, 0,0,0,8'h00,3,1));
        // record wins over play; stop_rec with a sample stores it
        tbl.push_back(v(1,0,1,0,8'h00,0, 0,0,0,8'h00,3,0));
        tbl.push_back(v(0,1,0,1,8'h55,0, 1,1,0,8'h00,0,0));
        tbl.push_back(v(0,1,0,0,8'h00,0, 0,0,0,8'h00,1,1));
        tbl.push_back(v(0,0,1,0,8'h00,0, 0,0,0,8'h00,1,0));
        tbl.push_back(v(0,0,0,0,8'h00,1, 1,0,1,8'h55,1,0));
        // empty recording, then start_play with count 0 is ignored
        tbl.push_back(v(1,0,0,0,8'h00,0, 0,0,0,8'h00,1,1));
        tbl.push_back(v(0,1,0,0,8'h00,0, 1,1,0,8'h00,0,0));
        tbl.push_back(v(0,0,1,0,8'h00,0, 0,0,0,8'h00,0,1));
        tbl.push_back(v(0,0,0,0,8'h00,0, 0,0,0,8'h00,0,0));
        // full: six samples offered, four stored
        tbl.push_back(v(1,0,0,0,8'h00,0, 0,0,0,8'h00,0,0));
        tbl.push_back(v(0,0,0,1,8'hA0,0, 1,1,0,8'h00,0,0));
        tbl.push_back(v(0,0,0,1,8'hA1,0, 1,1,0,8'h00,1,0));
        tbl.push_back(v(0,0,0,1,8'hA2,0, 1,1,0,8'h00,2,0));
        tbl.push_back(v(0,0,0,1,8'hA3,0, 1,1,0,8'h00,3,0));
        tbl.push_back(v(0,0,0,1,8'hA4,0, 0,0,0,8'h00,4,1));
        tbl.push_back(v(0,0,0,1,8'hA5,0, 0,0,0,8'h00,4,0));
        tbl.push_back(v(0,0,1,0,8'h00,1, 0,0,0,8'h00,4,0));
        tbl.push_back(v(0,0,0,0,8'h00,1, 1,0,1,8'hA0,4,0));
        tbl.push_back(v(0,0,0,0,8'h00,1, 1,0,1,8'hA1,4,0));
        tbl.push_back(v(0,0,0,0,8'h00,1, 1,0,1,8'hA2,4,0));
        tbl.push_back(v(0,0,0,0,8'h00,1, 1,0,1,8'hA3,4,0));
        tbl.push_back(v(0,0,0,0,8'h00,0, 0,0,0,8'h00,4,1));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].sr, tbl[i].stp, tbl[i].sp, tbl[i].iv, tbl[i].d, tbl[i].ordy);
            chk($sformatf("row%0d_busy", i), busy, tbl[i].busy);
            chk($sformatf("row%0d_in_ready", i), in_ready, tbl[i].inr);
            chk($sformatf("row%0d_out_valid", i), out_valid, tbl[i].ov);
            chk($sformatf("row%0d_count", i), count, tbl[i].cnt);
            chk($sformatf("row%0d_done", i), done_tick, tbl[i].done);
            if (tbl[i].ov) chk($sformatf("row%0d_out_data", i), out_data, tbl[i].od);
            tick();
        end

        // reset in the middle of playback after two of three samples
        drive(1,0,0,0,8'h00,0); tick();
        drive(0,0,0,1,8'hB1,0); tick();
        drive(0,0,0,1,8'hB2,0); tick();
        drive(0,0,0,1,8'hB3,0); tick();
        drive(0,1,0,0,8'h00,0); tick();
        drive(0,0,1,0,8'h00,1); tick();
        drive(0,0,0,0,8'h00,1); tick();
        drive(0,0,0,0,8'h00,1); tick();
        chk("mid_play_out_data", out_data, 8'hB3);
        #2 reset = 1'b1;
        #1;
        chk("areset_busy", busy, 0);
        chk("areset_out_valid", out_valid, 0);
        chk("areset_count", count, 0);
        chk("areset_done", done_tick, 0);
        mode = 0; pidx = 0; mdone = 0; q.delete();
        #1 reset = 1'b0;
        @(posedge clk); #1;
        drive(0,0,0,0,8'h00,0); tick();
        drive(1,0,0,0,8'h00,0); tick();
        drive(0,0,0,1,8'hC0,0);
        chk("rerec_addr", ram_addr, 0);
        tick();
        drive(0,1,0,0,8'h00,0); tick();
        drive(0,0,1,0,8'h00,0); tick();
        drive(0,0,0,0,8'h00,1);
        chk("rerec_play", out_data, 8'hC0);
        tick();
        drive(0,0,0,0,8'h00,0); tick();

        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 15) == 0, $urandom_range(0, 11) == 0,
                  $urandom_range(0, 9) == 0, 1'($urandom_range(0, 1)),
                  8'($urandom), $urandom_range(0, 2) != 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
